// File: rtl/gate_truth_sequencer_if.sv
// Stimulus/result bundle between the truth-table sequencer and the gate under test.
// The master side is the sequencer; the slave side is the gate/bench environment.
interface gate_truth_sequencer_if #(
    parameter int N_IN = 2
);
    logic              IN_start;
    logic              IN_dut_x;
    logic [N_IN-1:0]   OUT_vec;
    logic              OUT_expect;
    logic              OUT_busy;
    logic              OUT_done;
    logic              OUT_pass;
    logic [N_IN:0]     OUT_err_cnt;
    logic              OUT_fail_vld;
    logic [N_IN-1:0]   OUT_fail_vec;

    modport master (
        input  IN_start, IN_dut_x,
        output OUT_vec, OUT_expect, OUT_busy, OUT_done, OUT_pass,
               OUT_err_cnt, OUT_fail_vld, OUT_fail_vec
    );

    modport slave (
        output IN_start, IN_dut_x,
        input  OUT_vec, OUT_expect, OUT_busy, OUT_done, OUT_pass,
               OUT_err_cnt, OUT_fail_vld, OUT_fail_vec
    );
endinterface

// File: rtl/gate_truth_sequencer.sv
// Walks every input combination of a combinational gate in ascending order, holds each
// vector for SETTLE_CYCLES, samples the gate once and tallies mismatches against FUNC.
module gate_truth_sequencer #(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int FUNC          = 0
) (
    input  logic                   IN_clk,
    input  logic                   IN_rst,
    gate_truth_sequencer_if.master bus
);

    localparam int              CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST = '1;
    localparam logic [N_IN:0]   ERR_MAX  = {1'b1, {N_IN{1'b0}}};

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("gate_truth_sequencer: SETTLE_CYCLES must be at least 1");
    end
    if (N_IN < 1 || N_IN > 6) begin : g_bad_n_in
        $error("gate_truth_sequencer: N_IN must be in 1..6");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [N_IN-1:0] vec_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [N_IN:0]   err_cnt_q;
    logic [N_IN:0]   err_cnt_d;
    logic            fail_vld_q;
    logic [N_IN-1:0] fail_vec_q;
    logic            expect_w;
    logic            mismatch_w;

    function automatic logic expect_of(input logic [N_IN-1:0] v);
        case (FUNC)
            0:       return &v;
            1:       return |v;
            2:       return ^v;
            default: return ~&v;
        endcase
    endfunction

    assign expect_w   = expect_of(vec_q);
    assign mismatch_w = (bus.IN_dut_x != expect_w);
    assign err_cnt_d  = (mismatch_w && (err_cnt_q != ERR_MAX)) ? err_cnt_q + 1'b1 : err_cnt_q;

    always_ff @(posedge IN_clk) begin
        if (IN_rst) begin
            state_q    <= S_IDLE;
            vec_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            fail_vld_q <= 1'b0;
            fail_vec_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.IN_start) begin
                        state_q    <= S_SETTLE;
                        vec_q      <= '0;
                        cnt_q      <= CNT_LOAD;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        err_cnt_q  <= '0;
                        fail_vld_q <= 1'b0;
                        fail_vec_q <= '0;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= S_CHECK;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_CHECK: begin
                    err_cnt_q <= err_cnt_d;
                    // Only the first failing vector is kept for diagnosis.
                    if (mismatch_w && !fail_vld_q) begin
                        fail_vld_q <= 1'b1;
                        fail_vec_q <= vec_q;
                    end
                    if (vec_q == VEC_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == '0);
                    end else begin
                        state_q <= S_SETTLE;
                        vec_q   <= vec_q + 1'b1;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.OUT_vec      = vec_q;
    assign bus.OUT_expect   = expect_w;
    assign bus.OUT_busy     = busy_q;
    assign bus.OUT_done     = done_q;
    assign bus.OUT_pass     = pass_q;
    assign bus.OUT_err_cnt  = err_cnt_q;
    assign bus.OUT_fail_vld = fail_vld_q;
    assign bus.OUT_fail_vec = fail_vec_q;

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Bench for gate_truth_sequencer: a default AND instance and a 3-input XOR instance,
// each fed by a truth-table gate model with optional glitches while the vector settles.
module tb_gate_truth_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gate_truth_sequencer_if #(.N_IN(2)) if2 ();
    gate_truth_sequencer_if #(.N_IN(3)) if3 ();

    logic [3:0] tt2 = 4'h8;
    logic [7:0] tt3 = 8'h96;
    logic       g2  = 1'b0;
    logic       g3  = 1'b0;

    assign if2.IN_dut_x = tt2[if2.OUT_vec] ^ g2;
    assign if3.IN_dut_x = tt3[if3.OUT_vec] ^ g3;

    gate_truth_sequencer dut2 (
        .IN_clk (clk),
        .IN_rst (rst),
        .bus    (if2.master)
    );

    gate_truth_sequencer #(
        .N_IN          (3),
        .SETTLE_CYCLES (1),
        .FUNC          (2)
    ) dut3 (
        .IN_clk (clk),
        .IN_rst (rst),
        .bus    (if3.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] vec;
        logic [7:0] busy;
        logic [7:0] done;
        logic [7:0] pass;
        logic [7:0] err;
        logic [7:0] fvld;
        logic [7:0] fvec;
        logic [7:0] expct;
    } obs_t;

    // ---------------- reference model ----------------
    function automatic int n_of(input int cfg);
        return (cfg == 0) ? 2 : 3;
    endfunction

    function automatic int s_of(input int cfg);
        return (cfg == 0) ? 2 : 1;
    endfunction

    function automatic int f_of(input int cfg);
        return (cfg == 0) ? 0 : 2;
    endfunction

    function automatic bit exp_func(input int cfg, input int v);
        int ones;
        bit all_ones;
        ones     = $countones(v);
        all_ones = (ones == n_of(cfg));
        case (f_of(cfg))
            0:       return all_ones;
            1:       return ones > 0;
            2:       return (ones % 2) == 1;
            default: return !all_ones;
        endcase
    endfunction

    task automatic model(input int cfg, input logic [7:0] tt,
                         output int err, output int fvld, output int fvec, output int pass);
        err  = 0;
        fvld = 0;
        fvec = 0;
        for (int v = 0; v < (1 << n_of(cfg)); v++) begin
            if (tt[v] != exp_func(cfg, v)) begin
                err++;
                if (fvld == 0) begin
                    fvld = 1;
                    fvec = v;
                end
            end
        end
        pass = (err == 0) ? 1 : 0;
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic obs_t get_obs(input int cfg);
        obs_t o;
        if (cfg == 0) begin
            o.vec   = 8'(if2.OUT_vec);
            o.busy  = 8'(if2.OUT_busy);
            o.done  = 8'(if2.OUT_done);
            o.pass  = 8'(if2.OUT_pass);
            o.err   = 8'(if2.OUT_err_cnt);
            o.fvld  = 8'(if2.OUT_fail_vld);
            o.fvec  = 8'(if2.OUT_fail_vec);
            o.expct = 8'(if2.OUT_expect);
        end else begin
            o.vec   = 8'(if3.OUT_vec);
            o.busy  = 8'(if3.OUT_busy);
            o.done  = 8'(if3.OUT_done);
            o.pass  = 8'(if3.OUT_pass);
            o.err   = 8'(if3.OUT_err_cnt);
            o.fvld  = 8'(if3.OUT_fail_vld);
            o.fvec  = 8'(if3.OUT_fail_vec);
            o.expct = 8'(if3.OUT_expect);
        end
        return o;
    endfunction

    task automatic drive_start(input int cfg, input logic val);
        if (cfg == 0) if2.IN_start = val;
        else          if3.IN_start = val;
    endtask

    task automatic set_glitch(input int cfg, input logic val);
        if (cfg == 0) g2 = val;
        else          g3 = val;
    endtask

    task automatic set_tt(input int cfg, input logic [7:0] tt);
        if (cfg == 0) tt2 = tt[3:0];
        else          tt3 = tt;
    endtask

    // Runs one full sequence; the vector/expect trace is tallied into trace_bad.
    task automatic run_seq(input int cfg, input logic [7:0] tt, input bit glitch_en,
                           input bit mid_en, output int done_edge, output int trace_bad,
                           output obs_t o0, output obs_t of);
        int per;
        int total;
        int mid_j;
        per       = s_of(cfg) + 1;
        total     = (1 << n_of(cfg)) * per;
        mid_j     = mid_en ? int'($urandom_range(1, total - 1)) : -1;
        done_edge = -1;
        trace_bad = 0;
        set_tt(cfg, tt);
        drive_start(cfg, 1'b1);
        @(posedge clk);
        #1;
        drive_start(cfg, 1'b0);
        o0 = get_obs(cfg);
        of = o0;
        for (int j = 1; j <= total + 4; j++) begin
            if (glitch_en && (j % per) != 0) set_glitch(cfg, 1'($urandom_range(0, 1)));
            if (j == mid_j) drive_start(cfg, 1'b1);
            @(posedge clk);
            #1;
            drive_start(cfg, 1'b0);
            set_glitch(cfg, 1'b0);
            of = get_obs(cfg);
            if (of.done === 8'd1) begin
                done_edge = j;
                break;
            end
            if (of.vec !== 8'(j / per) || of.busy !== 8'd1 ||
                of.expct !== 8'(exp_func(cfg, j / per)))
                trace_bad++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        obs_t o;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int cfg = 0; cfg < 2; cfg++) begin
            o = get_obs(cfg);
            n_checks++;
            if ({o.vec, o.busy, o.done, o.pass, o.err, o.fvld, o.fvec} !== 56'd0) begin
                n_fail++;
                $display("FAIL reset_state cfg%0d: vec=%0d busy=%0d done=%0d pass=%0d err=%0d fvld=%0d fvec=%0d, expected all 0",
                         cfg, o.vec, o.busy, o.done, o.pass, o.err, o.fvld, o.fvec);
            end
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_gate(input string name, input int cfg, input logic [7:0] tt,
                             input bit mid_en);
        int done_edge, trace_bad, err, fvld, fvec, pass, total;
        obs_t o0, of;
        total = (1 << n_of(cfg)) * (s_of(cfg) + 1);
        model(cfg, tt, err, fvld, fvec, pass);
        run_seq(cfg, tt, 1'b0, mid_en, done_edge, trace_bad, o0, of);
        n_checks++;
        if (done_edge != total) begin
            n_fail++;
            $display("FAIL %s done_edge: got %0d, expected %0d", name, done_edge, total);
        end
        n_checks++;
        if (trace_bad != 0) begin
            n_fail++;
            $display("FAIL %s vec_trace: got %0d bad cycles, expected 0", name, trace_bad);
        end
        n_checks++;
        if (of.err !== 8'(err) || of.fvld !== 8'(fvld) || of.fvec !== 8'(fvec) || of.pass !== 8'(pass)) begin
            n_fail++;
            $display("FAIL %s results: got err=%0d fvld=%0d fvec=%0d pass=%0d, expected err=%0d fvld=%0d fvec=%0d pass=%0d",
                     name, of.err, of.fvld, of.fvec, of.pass, err, fvld, fvec, pass);
        end
        n_checks++;
        if (of.vec !== 8'((1 << n_of(cfg)) - 1) || of.busy !== 8'd0) begin
            n_fail++;
            $display("FAIL %s final_vec_busy: got vec=%0d busy=%0d, expected vec=%0d busy=0",
                     name, of.vec, of.busy, (1 << n_of(cfg)) - 1);
        end
    endtask

    task automatic test_restart_from_done();
        int done_edge, trace_bad;
        obs_t o0, of;
        run_seq(0, 8'h0F, 1'b0, 1'b0, done_edge, trace_bad, o0, of);
        run_seq(0, 8'h08, 1'b0, 1'b0, done_edge, trace_bad, o0, of);
        n_checks++;
        if (o0.done !== 8'd0 || o0.pass !== 8'd0 || o0.err !== 8'd0 || o0.fvld !== 8'd0 ||
            o0.fvec !== 8'd0 || o0.busy !== 8'd1 || o0.vec !== 8'd0) begin
            n_fail++;
            $display("FAIL restart_clear: got done=%0d pass=%0d err=%0d fvld=%0d fvec=%0d busy=%0d vec=%0d, expected 0/0/0/0/0/1/0",
                     o0.done, o0.pass, o0.err, o0.fvld, o0.fvec, o0.busy, o0.vec);
        end
        n_checks++;
        if (done_edge != 12 || of.pass !== 8'd1 || of.err !== 8'd0) begin
            n_fail++;
            $display("FAIL restart_rerun: got done_edge=%0d pass=%0d err=%0d, expected 12/1/0",
                     done_edge, of.pass, of.err);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        tt2 = 4'h0;
        drive_start(0, 1'b1);
        @(posedge clk);
        #1;
        drive_start(0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        o = get_obs(0);
        n_checks++;
        if (o.vec !== 8'd2 || o.busy !== 8'd1) begin
            n_fail++;
            $display("FAIL pre_reset_vec: got vec=%0d busy=%0d, expected vec=2 busy=1", o.vec, o.busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        o = get_obs(0);
        n_checks++;
        if ({o.vec, o.busy, o.done, o.pass, o.err, o.fvld, o.fvec} !== 56'd0) begin
            n_fail++;
            $display("FAIL mid_reset: vec=%0d busy=%0d done=%0d err=%0d fvld=%0d, expected all 0",
                     o.vec, o.busy, o.done, o.err, o.fvld);
        end
        // Start and reset on the same edge: reset has priority.
        rst = 1'b1;
        drive_start(0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_start(0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        o = get_obs(0);
        n_checks++;
        if (o.busy !== 8'd0 || o.vec !== 8'd0 || o.done !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_over_start: got busy=%0d vec=%0d done=%0d, expected 0/0/0", o.busy, o.vec, o.done);
        end
        test_gate("fresh_after_reset", 0, 8'h08, 1'b0);
    endtask

    task automatic test_random();
        int done_edge, trace_bad, err, fvld, fvec, pass, total, cfg;
        logic [7:0] tt;
        obs_t o0, of;
        for (int it = 0; it < 8; it++) begin
            cfg   = it % 2;
            tt    = 8'($urandom);
            if (cfg == 0) tt = tt & 8'h0F;
            total = (1 << n_of(cfg)) * (s_of(cfg) + 1);
            model(cfg, tt, err, fvld, fvec, pass);
            run_seq(cfg, tt, 1'b1, 1'b1, done_edge, trace_bad, o0, of);
            n_checks++;
            if (done_edge != total || trace_bad != 0) begin
                n_fail++;
                $display("FAIL rand%0d timing: got done_edge=%0d trace_bad=%0d, expected %0d/0",
                         it, done_edge, trace_bad, total);
            end
            n_checks++;
            if (of.err !== 8'(err) || of.fvld !== 8'(fvld) || of.fvec !== 8'(fvec) || of.pass !== 8'(pass)) begin
                n_fail++;
                $display("FAIL rand%0d results tt=%h: got err=%0d fvld=%0d fvec=%0d pass=%0d, expected %0d/%0d/%0d/%0d",
                         it, tt, of.err, of.fvld, of.fvec, of.pass, err, fvld, fvec, pass);
            end
        end
    endtask

    initial begin
        if2.IN_start = 1'b0;
        if3.IN_start = 1'b0;
        test_reset();
        test_gate("and_pass", 0, 8'h08, 1'b0);
        test_gate("stuck0", 0, 8'h00, 1'b0);
        test_gate("stuck1", 0, 8'h0F, 1'b0);
        test_gate("busy_start_ignored", 0, 8'h08, 1'b1);
        test_restart_from_done();
        test_reset_mid();
        test_gate("xor3_pass", 1, 8'h96, 1'b0);
        test_gate("xor3_vs_and", 1, 8'h80, 1'b0);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
